alu: RTL and testbench

8-bit combinational-datapath ALU with registered outputs. It takes two 8-bit operands and a 3-bit opcode, and computes arithmetic, logic or shift results. It also produces carry, signed-overflow and sign flags. It is the execution unit of the lab datapath, fed directly by operand registers and decoded opcode.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_addsub.sv | 27 ++
 rtl/alu.sv | 88 ++++++++
 tb/tb_alu.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, datapath width and the
// result bundle shared by the ALU top and its adder.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef struct packed {
    logic [ALU_W-1:0] z;
    logic             cout;
    logic             ov;
  } alu_res_t;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: 8-bit adder, sub=1 computes a+~b+1.
// Ports: a, b, sub in; sum, cout, ov (signed overflow) out.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             sub,
  output logic [ALU_W-1:0] sum,
  output logic             cout,
  output logic             ov
);

  logic [ALU_W-1:0] b_eff;
  logic [ALU_W:0]   full;

  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
    sum   = full[ALU_W-1:0];
    cout  = full[ALU_W];
    // same-sign operands into the adder, different-sign sum
    ov    = (a[ALU_W-1] == b_eff[ALU_W-1]) &&
            (sum[ALU_W-1] != a[ALU_W-1]);
  end

endmodule

// File: rtl/alu.sv
// alu: 8-bit ALU, registered z/ov/cout/sign, 1-cycle latency.
// Ports: clk, rst (sync, active-high), a, b, op in; z, ov, cout, sign out. SHL/SHR built only with ALU_SHIFT_EN.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       op,
  output logic [ALU_W-1:0] z,
  output logic             ov,
  output logic             cout,
  output logic             sign
);

  logic [ALU_W-1:0] as_sum;
  logic             as_cout;
  logic             as_ov;

  alu_addsub u_addsub (
    .a    (a),
    .b    (b),
    .sub  (op == OP_SUB),
    .sum  (as_sum),
    .cout (as_cout),
    .ov   (as_ov)
  );

  alu_res_t         res_d;
  logic [ALU_W-1:0] z_d, z_q;
  logic             ov_d, ov_q;
  logic             cout_d, cout_q;
  logic             sign_d, sign_q;

  always_comb begin
    res_d = '0;
    unique case (op)
      OP_ADD,
      OP_SUB: begin
        res_d.z    = as_sum;
        res_d.cout = as_cout;
        res_d.ov   = as_ov;
      end
      OP_AND: res_d.z = a & b;
      OP_OR:  res_d.z = a | b;
      OP_XOR: res_d.z = a ^ b;
      OP_NOT: res_d.z = ~a;
`ifdef ALU_SHIFT_EN
      OP_SHL: begin
        res_d.z    = {a[ALU_W-2:0], 1'b0};
        res_d.cout = a[ALU_W-1];
      end
      OP_SHR: begin
        res_d.z    = {1'b0, a[ALU_W-1:1]};
        res_d.cout = a[0];
      end
`else
      OP_SHL, OP_SHR: res_d = '0;
`endif
      default: res_d = '0;
    endcase
    z_d    = res_d.z;
    ov_d   = res_d.ov;
    cout_d = res_d.cout;
    sign_d = res_d.z[ALU_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z_q    <= '0;
      ov_q   <= 1'b0;
      cout_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      z_q    <= z_d;
      ov_q   <= ov_d;
      cout_q <= cout_d;
      sign_q <= sign_d;
    end
  end

  assign z    = z_q;
  assign ov   = ov_q;
  assign cout = cout_q;
  assign sign = sign_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table plus reset and
// back-to-back latency sequences for the alu.
module tb_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [2:0] op;
  logic [7:0] z;
  logic       ov, cout, sign;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .op   (op),
    .z    (z),
    .ov   (ov),
    .cout (cout),
    .sign (sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    logic       cout;
    logic       ov;
    logic       sign;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] o, logic [7:0] va,
                              logic [7:0] vb, logic [7:0] vz,
                              logic c, logic v, logic s);
    vec_t t;
    t.op = o; t.a = va; t.b = vb; t.z = vz;
    t.cout = c; t.ov = v; t.sign = s;
    return t;
  endfunction

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic chk_all(string nm, logic [7:0] ez,
                         logic ec, logic ev, logic es);
    chk({nm, ".z"},    z,           ez);
    chk({nm, ".cout"}, {7'd0, cout}, {7'd0, ec});
    chk({nm, ".ov"},   {7'd0, ov},   {7'd0, ev});
    chk({nm, ".sign"}, {7'd0, sign}, {7'd0, es});
  endtask

  initial begin
    vecs.push_back(mk(OP_ADD, 8'hA9, 8'h83, 8'h2C, 1, 1, 0));
    vecs.push_back(mk(OP_SUB, 8'hA9, 8'h83, 8'h26, 1, 0, 0));
    vecs.push_back(mk(OP_AND, 8'hA9, 8'h83, 8'h81, 0, 0, 1));
    vecs.push_back(mk(OP_OR,  8'hA9, 8'h83, 8'hAB, 0, 0, 1));
    vecs.push_back(mk(OP_ADD, 8'h69, 8'h43, 8'hAC, 0, 1, 1));
    vecs.push_back(mk(OP_XOR, 8'h69, 8'h43, 8'h2A, 0, 0, 0));
    vecs.push_back(mk(OP_NOT, 8'h69, 8'h43, 8'h96, 0, 0, 1));
    vecs.push_back(mk(OP_SUB, 8'hE9, 8'h53, 8'h96, 1, 0, 1));
    vecs.push_back(mk(OP_ADD, 8'h7F, 8'h01, 8'h80, 0, 1, 1));
    vecs.push_back(mk(OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 0, 0));
    vecs.push_back(mk(OP_SUB, 8'h00, 8'h01, 8'hFF, 0, 0, 1));
    vecs.push_back(mk(OP_SUB, 8'h80, 8'h01, 8'h7F, 1, 1, 0));
    vecs.push_back(mk(OP_SUB, 8'h55, 8'h55, 8'h00, 1, 0, 0));
`ifdef ALU_SHIFT_EN
    vecs.push_back(mk(OP_SHL, 8'hA9, 8'h00, 8'h52, 1, 0, 0));
    vecs.push_back(mk(OP_SHR, 8'hA9, 8'h00, 8'h54, 1, 0, 0));
    vecs.push_back(mk(OP_SHL, 8'h40, 8'hFF, 8'h80, 0, 0, 1));
    vecs.push_back(mk(OP_SHR, 8'h01, 8'hFF, 8'h00, 1, 0, 0));
`else
    vecs.push_back(mk(OP_SHL, 8'hA9, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SHR, 8'hA9, 8'h00, 8'h00, 0, 0, 0));
    vecs.push_back(mk(OP_SHL, 8'hFF, 8'hFF, 8'h00, 0, 0, 0));
`endif

    // reset dominates an operation that would set flags
    rst = 1'b1; op = OP_ADD; a = 8'hFF; b = 8'h01;
    @(posedge clk); #1;
    chk_all("reset", 8'h00, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk_all("rst_release", 8'h00, 1, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].z,
              vecs[i].cout, vecs[i].ov, vecs[i].sign);
    end

    // latency: new op right after each edge, result held until next
    @(negedge clk);
    op = OP_ADD; a = 8'hA9; b = 8'h83;
    @(posedge clk); #1;
    chk_all("lat_add", 8'h2C, 1, 1, 0);
    op = OP_SUB;
    #3 chk_all("lat_hold_add", 8'h2C, 1, 1, 0);
    @(posedge clk); #1;
    chk_all("lat_sub", 8'h26, 1, 0, 0);
    op = OP_AND;
    #3 chk_all("lat_hold_sub", 8'h26, 1, 0, 0);
    @(posedge clk); #1;
    chk_all("lat_and", 8'h81, 0, 0, 1);
    op = OP_NOT;
    @(posedge clk); #1;
    chk_all("lat_not", 8'h56, 0, 0, 0);

    // mid-stream reset then resume
    @(negedge clk);
    rst = 1'b1; op = OP_ADD; a = 8'h7F; b = 8'h01;
    @(posedge clk); #1;
    chk_all("mid_reset", 8'h00, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk_all("mid_resume", 8'h80, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
